// File: rtl/univ_shift_pkg.sv
// rtl/univ_shift_pkg.sv - mode encodings and FSM state type for the universal shift register
package univ_shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_ROR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - control, data and status bundle of the universal shift register
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic [1:0]       mode;
  logic             start;
  logic [CNT_W-1:0] shift_len;
  logic             ser_in;
  logic             ser_out;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output load, d_in, mode, start, shift_len, ser_in,
    input  ser_out, q, busy, done
  );

  modport slave (
    input  load, d_in, mode, start, shift_len, ser_in,
    output ser_out, q, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_ctrl.sv
// rtl/univ_shift_reg_ctrl.sv - sequence FSM and down-counter driving the shift datapath
module shift_ctrl
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] shift_len,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       mode_lat
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       mode_nxt;
  logic [CNT_W-1:0] len_clamped;

  assign len_clamped = (shift_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mode_lat <= MODE_HOLD;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mode_lat <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_lat;
    if (load) begin
      // load aborts silently and swallows a coincident start
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && mode != MODE_HOLD) begin
            mode_nxt  = mode;
            cnt_nxt   = len_clamped;
            state_nxt = (len_clamped != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
        end
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = (state == ST_SHIFT) && !load;
    busy     = (state == ST_SHIFT);
    done     = (state == ST_DONE);
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register: parallel load plus counted shift/rotate sequences
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            rst_n,
  univ_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic             shift_en;
  logic [1:0]       mode_lat;

  shift_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (bus.load),
    .start     (bus.start),
    .mode      (bus.mode),
    .shift_len (bus.shift_len),
    .shift_en  (shift_en),
    .busy      (bus.busy),
    .done      (bus.done),
    .mode_lat  (mode_lat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bus.load) begin
      q <= bus.d_in;
    end else if (shift_en) begin
      case (mode_lat)
        MODE_SHR: q <= {bus.ser_in, q[WIDTH-1:1]};
        MODE_SHL: q <= {q[WIDTH-2:0], bus.ser_in};
        MODE_ROR: q <= {q[0], q[WIDTH-1:1]};
        default:  q <= q;
      endcase
    end
  end

  // ser_out previews the bit that the next shift in the latched direction drops
  always_comb begin
    case (mode_lat)
      MODE_SHR, MODE_ROR: bus.ser_out = q[0];
      MODE_SHL:           bus.ser_out = q[WIDTH-1];
      default:            bus.ser_out = 1'b0;
    endcase
  end

  assign bus.q = q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg at WIDTH=8
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       ser;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".q"},       32'(bus.q),       32'(e.q));
    check({e.tag, ".busy"},    32'(bus.busy),    32'(e.busy));
    check({e.tag, ".done"},    32'(bus.done),    32'(e.done));
    check({e.tag, ".ser_out"}, 32'(bus.ser_out), 32'(e.ser));
  endtask

  task automatic expect_now(input string tag, input logic [7:0] q, input logic b,
                            input logic d, input logic s);
    sb.push_back('{tag, q, b, d, s});
    compare_head();
  endtask

  task automatic tick(input string tag, input logic [7:0] q, input logic b,
                      input logic d, input logic s);
    sb.push_back('{tag, q, b, d, s});
    @(posedge clk);
    #1;
    compare_head();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v, input logic s);
    bus.load = 1'b1;
    bus.d_in = v;
    tick("load", v, 1'b0, 1'b0, s);
    bus.load = 1'b0;
  endtask

  task automatic go(input logic [1:0] m, input logic [CNT_W-1:0] len);
    bus.mode      = m;
    bus.shift_len = len;
    bus.start     = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  e;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.d_in      = '0;
    bus.mode      = 2'b00;
    bus.start     = 1'b0;
    bus.shift_len = '0;
    bus.ser_in    = 1'b0;
    repeat (2) @(negedge clk);
    expect_now("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    do_load(8'hD0, 1'b0);

    // shift right, mode/len changes after start must not matter
    bus.ser_in = 1'b1;
    go(2'b01, 4'd3);
    tick("shr_start", 8'hD0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0; bus.mode = 2'b10; bus.shift_len = 4'd7;
    tick("shr1", 8'hE8, 1'b1, 1'b0, 1'b0);
    tick("shr2", 8'hF4, 1'b1, 1'b0, 1'b0);
    tick("shr3", 8'hFA, 1'b0, 1'b1, 1'b0);
    tick("shr_idle", 8'hFA, 1'b0, 1'b0, 1'b0);

    do_load(8'hD0, 1'b0);
    bus.ser_in = 1'b0;
    go(2'b10, 4'd2);
    tick("shl_start", 8'hD0, 1'b1, 1'b0, 1'b1);
    bus.start = 1'b0;
    tick("shl1", 8'hA0, 1'b1, 1'b0, 1'b1);
    tick("shl2", 8'h40, 1'b0, 1'b1, 1'b0);
    tick("shl_idle", 8'h40, 1'b0, 1'b0, 1'b0);

    do_load(8'hD0, 1'b1);
    go(2'b11, 4'd4);
    tick("ror_start", 8'hD0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.ser_in = 1'b1; tick("ror1", 8'h68, 1'b1, 1'b0, 1'b0);
    bus.ser_in = 1'b0; tick("ror2", 8'h34, 1'b1, 1'b0, 1'b0);
    bus.ser_in = 1'b1; tick("ror3", 8'h1A, 1'b1, 1'b0, 1'b0);
    bus.ser_in = 1'b0; tick("ror4", 8'h0D, 1'b0, 1'b1, 1'b1);
    tick("ror_idle", 8'h0D, 1'b0, 1'b0, 1'b1);

    do_load(8'hD0, 1'b0);
    go(2'b00, 4'd3);
    tick("hold_start", 8'hD0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick("hold_idle", 8'hD0, 1'b0, 1'b0, 1'b0);

    go(2'b01, 4'd0);
    tick("len0_start", 8'hD0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick("len0_idle", 8'hD0, 1'b0, 1'b0, 1'b0);

    // oversize length clamps to WIDTH shifts
    bus.ser_in = 1'b1;
    go(2'b10, 4'd15);
    tick("len15_start", 8'hD0, 1'b1, 1'b0, 1'b1);
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      w = (16'h00D0 << k) | ((16'd1 << k) - 16'd1);
      e = w[7:0];
      tick($sformatf("len15_%0d", k), e, (k < 8), (k == 8), e[7]);
    end
    tick("len15_idle", 8'hFF, 1'b0, 1'b0, 1'b1);

    do_load(8'hD0, 1'b1);
    bus.ser_in = 1'b0;
    go(2'b01, 4'd5);
    tick("abort_start", 8'hD0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick("abort_shift", 8'h68, 1'b1, 1'b0, 1'b0);
    bus.load = 1'b1; bus.d_in = 8'h5A; bus.start = 1'b1;
    tick("abort_load", 8'h5A, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0; bus.start = 1'b0;
    tick("abort_after1", 8'h5A, 1'b0, 1'b0, 1'b0);
    tick("abort_after2", 8'h5A, 1'b0, 1'b0, 1'b0);

    do_load(8'hD0, 1'b0);
    go(2'b01, 4'd3);
    tick("busy_start", 8'hD0, 1'b1, 1'b0, 1'b0);
    bus.shift_len = 4'd1;
    tick("busy_restart", 8'h68, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick("busy2", 8'h34, 1'b1, 1'b0, 1'b0);
    tick("busy3", 8'h1A, 1'b0, 1'b1, 1'b0);
    tick("busy_idle", 8'h1A, 1'b0, 1'b0, 1'b0);

    do_load(8'hD0, 1'b0);
    go(2'b01, 4'd5);
    tick("rst_start", 8'hD0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick("rst_shift", 8'h68, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_now("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick("rst_release", 8'h00, 1'b0, 1'b0, 1'b0);
    tick("rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
